// File: rtl/aud_sram_ctrl.sv
// SRAM access controller for the audio recorder: buffers sample writes in a small FIFO,
// arbitrates them against single-word playback reads and drives async-SRAM strobes.
module aud_sram_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 2,
    parameter int RD_CYCLES  = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_wr_valid,
    input  logic [19:0]                   i_wr_addr,
    input  logic [15:0]                   i_wr_data,
    output logic                          o_wr_ready,
    input  logic                          i_rd_req,
    input  logic [19:0]                   i_rd_addr,
    output logic                          o_rd_ready,
    output logic [15:0]                   o_rd_data,
    output logic                          o_rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [19:0]                   o_sram_addr,
    output logic [15:0]                   o_sram_dq,
    output logic                          o_sram_dq_oe,
    input  logic [15:0]                   i_sram_dq,
    output logic                          o_sram_ce_n,
    output logic                          o_sram_oe_n,
    output logic                          o_sram_we_n,
    output logic                          o_sram_lb_n,
    output logic                          o_sram_ub_n
);

    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int LW      = PW + 1;
    localparam int CNT_MAX = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_ADDR,
        ST_RD_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            wr_ready_q, wr_ready_d;
    logic            rd_pend_q, rd_pend_d;
    logic [19:0]     rd_addr_q, rd_addr_d;
    logic            rd_ready_q, rd_ready_d;
    logic            rd_valid_q, rd_valid_d;
    logic [15:0]     rd_data_q, rd_data_d;
    logic [19:0]     sram_addr_q, sram_addr_d;
    logic [15:0]     sram_dq_q, sram_dq_d;
    logic            dq_oe_q, dq_oe_d;
    logic            ce_n_q, ce_n_d;
    logic            oe_n_q, oe_n_d;
    logic            we_n_q, we_n_d;

    logic [35:0]     mem_q [FIFO_DEPTH];

    logic            push, pop, rd_accept;
    logic            fifo_empty, fifo_full, wr_avail, rd_want;
    logic [35:0]     head;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wptr_q] <= {i_wr_addr, i_wr_data};
        end
    end

    always_comb begin
        push       = i_wr_valid & wr_ready_q;
        rd_accept  = i_rd_req & rd_ready_q;
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LW'(FIFO_DEPTH));
        wr_avail   = !fifo_empty || push;
        rd_want    = rd_pend_q || rd_accept;
        // Empty FIFO forwards the incoming push so an idle controller starts next cycle.
        head       = fifo_empty ? {i_wr_addr, i_wr_data} : mem_q[rptr_q];

        pop         = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_pend_d   = rd_pend_q;
        rd_addr_d   = rd_addr_q;
        rd_ready_d  = rd_ready_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        sram_addr_d = sram_addr_q;
        sram_dq_d   = sram_dq_q;
        dq_oe_d     = dq_oe_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;

        if (rd_accept) begin
            rd_pend_d  = 1'b1;
            rd_addr_d  = i_rd_addr;
            rd_ready_d = 1'b0;
        end
        if (rd_valid_q) begin
            rd_ready_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (fifo_full || (!rd_want && wr_avail)) begin
                    pop         = 1'b1;
                    state_d     = ST_WR_SETUP;
                    sram_addr_d = head[35:16];
                    sram_dq_d   = head[15:0];
                    dq_oe_d     = 1'b1;
                    ce_n_d      = 1'b0;
                    we_n_d      = 1'b1;
                    oe_n_d      = 1'b1;
                end else if (rd_want) begin
                    state_d     = ST_RD_ADDR;
                    sram_addr_d = rd_pend_q ? rd_addr_q : i_rd_addr;
                    rd_pend_d   = 1'b0;
                    dq_oe_d     = 1'b0;
                    ce_n_d      = 1'b0;
                    oe_n_d      = 1'b1;
                    we_n_d      = 1'b1;
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                we_n_d  = 1'b0;
                cnt_d   = CW'(WE_CYCLES - 1);
            end
            ST_WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_HOLD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WR_HOLD: begin
                state_d = ST_IDLE;
                ce_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_WAIT;
                oe_n_d  = 1'b0;
                cnt_d   = CW'(RD_CYCLES - 1);
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    rd_data_d  = i_sram_dq;
                    rd_valid_d = 1'b1;
                    oe_n_d     = 1'b1;
                    ce_n_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
        endcase

        wptr_d     = wptr_q + PW'(push);
        rptr_d     = rptr_q + PW'(pop);
        level_d    = level_q + LW'(push) - LW'(pop);
        wr_ready_d = (level_d != LW'(FIFO_DEPTH));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            wr_ready_q  <= 1'b1;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_ready_q  <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            sram_addr_q <= '0;
            sram_dq_q   <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            wr_ready_q  <= wr_ready_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            rd_ready_q  <= rd_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            sram_addr_q <= sram_addr_d;
            sram_dq_q   <= sram_dq_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
        end
    end

    assign o_wr_ready   = wr_ready_q;
    assign o_rd_ready   = rd_ready_q;
    assign o_rd_data    = rd_data_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_fifo_level = level_q;
    assign o_sram_addr  = sram_addr_q;
    assign o_sram_dq    = sram_dq_q;
    assign o_sram_dq_oe = dq_oe_q;
    assign o_sram_ce_n  = ce_n_q;
    assign o_sram_oe_n  = oe_n_q;
    assign o_sram_we_n  = we_n_q;
    assign o_sram_lb_n  = 1'b0;
    assign o_sram_ub_n  = 1'b0;

endmodule

// File: tb/tb_aud_sram_ctrl.sv
// Directed bench for aud_sram_ctrl with a behavioural 1M x 16 SRAM and a strobe monitor.
module tb_aud_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid, rd_req;
    logic [19:0] wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic        wr_ready, rd_ready, rd_valid;
    logic [15:0] rd_data;
    logic [2:0]  level;
    logic [19:0] s_addr;
    logic [15:0] s_dq, s_rd;
    logic        s_dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;

    always #5 clk = ~clk;

    aud_sram_ctrl #(.FIFO_DEPTH(4), .WE_CYCLES(2), .RD_CYCLES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ready(rd_ready),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_fifo_level(level),
        .o_sram_addr(s_addr), .o_sram_dq(s_dq), .o_sram_dq_oe(s_dq_oe), .i_sram_dq(s_rd),
        .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
        .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SRAM model and strobe monitor, evaluated mid-cycle
    logic [15:0] sram [logic [19:0]];
    logic [19:0] wl_addr [$];
    logic [15:0] wl_data [$];
    int          wl_cyc  [$];
    int cyc = 0, viol = 0, we_lo = 0, ce_act = 0, rdv_cnt = 0;
    logic prev_we_n = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && !ce_n && !we_n) begin
            sram[s_addr] = s_dq;
            if (prev_we_n) begin
                wl_addr.push_back(s_addr);
                wl_data.push_back(s_dq);
                wl_cyc.push_back(cyc);
            end
        end
        prev_we_n = we_n;
        if (!we_n && !oe_n) viol++;
        if (s_dq_oe && !oe_n) viol++;
        if (lb_n || ub_n) viol++;
        if (!we_n) we_lo++;
        if (!ce_n) ce_act++;
        if (rd_valid) rdv_cnt++;
        if (!ce_n && !oe_n) s_rd = sram.exists(s_addr) ? sram[s_addr] : 16'hDEAD;
        else s_rd = 16'h0000;
    end

    task automatic wait_rdv(input string tag);
        int n;
        n = 0;
        while (rd_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_rdv_seen"}, {31'd0, rd_valid}, 32'd1);
    endtask

    initial begin
        int b, i, bad, saw_full, pushes, reads, ce_base;
        logic acc;
        wr_valid = 0; rd_req = 0; wr_addr = '0; rd_addr = '0; wr_data = '0; s_rd = '0;

        #12;
        chk("rst_ctl", {26'd0, ce_n, oe_n, we_n, lb_n, ub_n, s_dq_oe}, 32'b111000);
        chk("rst_addr", {12'd0, s_addr}, 32'd0);
        chk("rst_dq", {16'd0, s_dq}, 32'd0);
        chk("rst_client", {29'd0, wr_ready, rd_ready, rd_valid}, 32'b110);
        chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single write
        we_lo = 0;
        wr_valid = 1; wr_addr = 20'h00010; wr_data = 16'hABCD;
        chk("w1_ready", {31'd0, wr_ready}, 32'd1);
        step();
        wr_valid = 0;
        chk("w1_setup_ctl", {28'd0, ce_n, we_n, oe_n, s_dq_oe}, 32'b0111);
        chk("w1_setup_addr", {12'd0, s_addr}, 32'h10);
        chk("w1_setup_dq", {16'd0, s_dq}, 32'hABCD);
        chk("w1_level", {29'd0, level}, 32'd0);
        for (int k = 2; k <= 3; k++) begin
            step();
            chk($sformatf("w1_pulse%0d_ctl", k), {28'd0, ce_n, we_n, oe_n, s_dq_oe}, 32'b0011);
            chk($sformatf("w1_pulse%0d_bus", k), {s_addr[15:0], s_dq}, 32'h0010ABCD);
        end
        step();
        chk("w1_hold_ctl", {28'd0, ce_n, we_n, oe_n, s_dq_oe}, 32'b0111);
        chk("w1_hold_bus", {s_addr[15:0], s_dq}, 32'h0010ABCD);
        step();
        chk("w1_idle_ctl", {28'd0, ce_n, we_n, oe_n, s_dq_oe}, 32'b1110);
        chk("w1_we_lo_cycles", we_lo, 32'd2);
        chk("w1_mem", {16'd0, sram[20'h00010]}, 32'hABCD);

        // Burst of six
        b = wl_addr.size(); i = 0; bad = 0; saw_full = 0;
        wr_valid = 1; wr_addr = 20'h100; wr_data = 16'h5A00;
        for (int c = 0; c < 60; c++) begin
            if (wr_ready !== (level != 3'd4)) bad++;
            if (wr_ready === 1'b0) saw_full = 1;
            acc = wr_valid && wr_ready;
            step();
            if (acc) begin
                i++;
                if (i < 6) begin
                    wr_addr = 20'h100 + 20'(i);
                    wr_data = 16'h5A00 + 16'(i);
                end else begin
                    wr_valid = 0;
                end
            end
        end
        chk("burst_pushed", i, 32'd6);
        chk("burst_ready_vs_level", bad, 32'd0);
        chk("burst_saw_full", saw_full, 32'd1);
        chk("burst_count", wl_addr.size() - b, 32'd6);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("burst%0d_addr", j), {12'd0, wl_addr[b+j]}, 32'h100 + 32'(j));
            chk($sformatf("burst%0d_data", j), {16'd0, wl_data[b+j]}, 32'h5A00 + 32'(j));
            if (j > 0) chk($sformatf("burst%0d_spacing", j), wl_cyc[b+j] - wl_cyc[b+j-1], 32'd5);
        end
        chk("burst_level_end", {29'd0, level}, 32'd0);

        // Read-back at the top address
        wr_valid = 1; wr_addr = 20'hFFFFF; wr_data = 16'h1234;
        step();
        wr_valid = 0;
        repeat (6) step();
        rd_req = 1; rd_addr = 20'hFFFFF;
        chk("rb_rd_ready", {31'd0, rd_ready}, 32'd1);
        step();
        rd_req = 0;
        chk("rb_addr", {12'd0, s_addr}, 32'hFFFFF);
        chk("rb_dq_oe", {31'd0, s_dq_oe}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("rb%0d_valid", k), {31'd0, rd_valid}, (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("rb%0d_ready", k), {31'd0, rd_ready}, (k == 5) ? 32'd1 : 32'd0);
            chk($sformatf("rb%0d_oe_n", k), {31'd0, oe_n}, (k == 2 || k == 3) ? 32'd0 : 32'd1);
            if (k >= 4) chk($sformatf("rb%0d_data", k), {16'd0, rd_data}, 32'h1234);
            step();
        end

        // Read and write in the same cycle, FIFO below full: read first
        b = wl_addr.size();
        wr_valid = 1; wr_addr = 20'h00200; wr_data = 16'h7777;
        rd_req = 1; rd_addr = 20'h00010;
        step();
        wr_valid = 0; rd_req = 0;
        chk("pa_first_ctl", {28'd0, ce_n, we_n, oe_n, s_dq_oe}, 32'b0110);
        chk("pa_first_addr", {12'd0, s_addr}, 32'h10);
        wait_rdv("pa");
        chk("pa_no_write_before_read", wl_addr.size() - b, 32'd0);
        chk("pa_rd_data", {16'd0, rd_data}, 32'hABCD);
        repeat (8) step();
        chk("pa_write_after", wl_addr.size() - b, 32'd1);
        chk("pa_write_addr", {12'd0, wl_addr[b]}, 32'h200);

        // Read requested as the FIFO fills: one write runs first
        b = wl_addr.size();
        for (int k = 0; k < 5; k++) begin
            wr_valid = 1; wr_addr = 20'h300 + 20'(k); wr_data = 16'h3000 + 16'(k);
            if (k == 4) begin
                rd_req = 1; rd_addr = 20'h00200;
                chk("pb_rd_ready", {31'd0, rd_ready}, 32'd1);
            end
            chk($sformatf("pb_wr_ready%0d", k), {31'd0, wr_ready}, 32'd1);
            step();
        end
        wr_valid = 0; rd_req = 0;
        chk("pb_full", {29'd0, level}, 32'd4);
        wait_rdv("pb");
        chk("pb_writes_before_read", wl_addr.size() - b, 32'd2);
        chk("pb_rd_data", {16'd0, rd_data}, 32'h7777);
        repeat (20) step();
        chk("pb_writes_total", wl_addr.size() - b, 32'd5);

        // Reset during the write pulse
        wr_valid = 1; wr_addr = 20'h400; wr_data = 16'h4444;
        step();
        wr_addr = 20'h401; wr_data = 16'h4445;
        step();
        wr_valid = 0;
        chk("rw_pre_we", {31'd0, we_n}, 32'd0);
        chk("rw_pre_level", {29'd0, level}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_async_ctl", {28'd0, ce_n, we_n, oe_n, s_dq_oe}, 32'b1110);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rw_level", {29'd0, level}, 32'd0);
        chk("rw_ready", {30'd0, wr_ready, rd_ready}, 32'b11);
        ce_base = ce_act;
        repeat (10) step();
        chk("rw_quiet", ce_act - ce_base, 32'd0);

        // Random interleaved traffic
        b = wl_addr.size(); reads = rdv_cnt; pushes = 0; i = 0;
        for (int c = 0; c < 3000; c++) begin
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_addr  = 20'h800 + 20'($urandom_range(0, 15));
            wr_data  = 16'($urandom);
            rd_req   = ($urandom_range(0, 3) == 0);
            rd_addr  = 20'h800 + 20'($urandom_range(0, 15));
            if (wr_valid && wr_ready) pushes++;
            if (rd_req && rd_ready) i++;
            step();
        end
        wr_valid = 0; rd_req = 0;
        repeat (40) step();
        chk("rand_writes", wl_addr.size() - b, pushes);
        chk("rand_reads", rdv_cnt - reads, i);
        chk("rand_level", {29'd0, level}, 32'd0);
        chk("strobe_safety", viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
